rtc_bus_ctrl: RTL

Physical-bus master for the external real-time clock chip, sitting directly downstream of the RTC register bank.
- The register bank issues single-byte write or read requests (address + data).
- This block sequences the multiplexed address/data bus: CS, RD, WR, A/D select, and tri-state enable of the AD lines.
- It returns read bytes with a one-cycle done pulse.
- One transaction is in flight at a time; no queueing.

---
 rtl/rtc_bus_ctrl.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/rtc_bus_ctrl.sv
// rtc_bus_ctrl: single-transaction master for the external RTC's multiplexed
// address/data bus. Each request runs an address phase, a CS-high gap and a
// data phase, then pulses done for one cycle.
// Optional feature macro: RTC_RDSYNC_EN (2-flop synchroniser on ad_in,
// read data strobe lengthened by 2 cycles to cover the synchroniser delay).
module rtc_bus_ctrl #(
  parameter int T_SETUP  = 2,
  parameter int T_STROBE = 4,
  parameter int T_HOLD   = 2,
  parameter int T_GAP    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_wr,
  input  logic       start_rd,
  input  logic [7:0] addr,
  input  logic [7:0] wr_data,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       done,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       a_d,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  input  logic [7:0] ad_in
);

  // Zero-length timings are promoted to one cycle.
  localparam int SETUP_C  = (T_SETUP  < 1) ? 1 : T_SETUP;
  localparam int STROBE_C = (T_STROBE < 1) ? 1 : T_STROBE;
  localparam int HOLD_C   = (T_HOLD   < 1) ? 1 : T_HOLD;
  localparam int GAP_C    = (T_GAP    < 1) ? 1 : T_GAP;
`ifdef RTC_RDSYNC_EN
  localparam int RD_EXTRA = 2;
`else
  localparam int RD_EXTRA = 0;
`endif
  localparam int CW = 16;

  // Counter load values: the counter holds "cycles remaining minus one".
  localparam logic [CW-1:0] LD_SETUP   = CW'(SETUP_C - 1);
  localparam logic [CW-1:0] LD_STROBE  = CW'(STROBE_C - 1);
  localparam logic [CW-1:0] LD_RSTROBE = CW'(STROBE_C + RD_EXTRA - 1);
  localparam logic [CW-1:0] LD_HOLD    = CW'(HOLD_C - 1);
  localparam logic [CW-1:0] LD_GAP     = CW'(GAP_C - 1);

  typedef enum logic [3:0] {
    IDLE, A_SETUP, A_STROBE, A_HOLD, GAP, D_SETUP, D_STROBE, D_HOLD, DONE
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          is_wr_reg, is_wr_next;
  logic [7:0]    addr_reg, addr_next;
  logic [7:0]    wdata_reg, wdata_next;
  logic [7:0]    ad_sample;
  logic          accept, cnt_done, capture;

  // Next-cycle output values, registered below so every output is a flop.
  logic       cs_n_next, rd_n_next, wr_n_next, a_d_next, ad_oe_next;
  logic       busy_next, done_next;
  logic [7:0] ad_out_next;

  assign accept   = (state_reg == IDLE) && (start_wr || start_rd);
  assign cnt_done = (cnt_reg == '0);
  // Read byte is taken on the edge that ends the final data-strobe cycle.
  assign capture  = (state_reg == D_STROBE) && cnt_done && !is_wr_reg;

`ifdef RTC_RDSYNC_EN
  logic [7:0] sync1_reg, sync2_reg;

  // Two-flop synchroniser on the pad readback.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= ad_in;
      sync2_reg <= sync1_reg;
    end
  end

  assign ad_sample = sync2_reg;
`else
  assign ad_sample = ad_in;
`endif

  // State, duration counter and latched request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      is_wr_reg <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      is_wr_reg <= is_wr_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
    end
  end

  // Next-state logic: each timed state loads its length on entry and exits
  // when the counter reaches zero.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    is_wr_next = is_wr_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    if (!cnt_done) cnt_next = cnt_reg - CW'(1);
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = A_SETUP;
          cnt_next   = LD_SETUP;
          is_wr_next = start_wr;   // write wins when both requests arrive
          addr_next  = addr;
          wdata_next = wr_data;
        end
      end
      A_SETUP:  if (cnt_done) begin state_next = A_STROBE; cnt_next = LD_STROBE; end
      A_STROBE: if (cnt_done) begin state_next = A_HOLD;   cnt_next = LD_HOLD;   end
      A_HOLD:   if (cnt_done) begin state_next = GAP;      cnt_next = LD_GAP;    end
      GAP:      if (cnt_done) begin state_next = D_SETUP;  cnt_next = LD_SETUP;  end
      D_SETUP: begin
        if (cnt_done) begin
          state_next = D_STROBE;
          cnt_next   = is_wr_reg ? LD_STROBE : LD_RSTROBE;
        end
      end
      D_STROBE: if (cnt_done) begin state_next = D_HOLD; cnt_next = LD_HOLD; end
      D_HOLD:   if (cnt_done) begin state_next = DONE;   cnt_next = '0;      end
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Bus values decoded from the state being entered.
  always_comb begin
    cs_n_next   = 1'b1;
    rd_n_next   = 1'b1;
    wr_n_next   = 1'b1;
    a_d_next    = 1'b1;
    ad_oe_next  = 1'b0;
    ad_out_next = 8'h00;
    busy_next   = (state_next != IDLE);
    done_next   = (state_next == DONE);
    case (state_next)
      A_SETUP, A_STROBE, A_HOLD: begin
        cs_n_next   = 1'b0;
        a_d_next    = 1'b0;
        ad_oe_next  = 1'b1;
        ad_out_next = addr_next;
        wr_n_next   = (state_next != A_STROBE);
      end
      D_SETUP, D_STROBE, D_HOLD: begin
        cs_n_next = 1'b0;
        if (is_wr_next) begin
          ad_oe_next  = 1'b1;
          ad_out_next = wdata_next;
          wr_n_next   = (state_next != D_STROBE);
        end else begin
          rd_n_next = (state_next != D_STROBE);
        end
      end
      default: ;
    endcase
  end

  // Registered bus outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      cs_n   <= 1'b1;
      rd_n   <= 1'b1;
      wr_n   <= 1'b1;
      a_d    <= 1'b1;
      ad_oe  <= 1'b0;
      ad_out <= 8'h00;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      cs_n   <= cs_n_next;
      rd_n   <= rd_n_next;
      wr_n   <= wr_n_next;
      a_d    <= a_d_next;
      ad_oe  <= ad_oe_next;
      ad_out <= ad_out_next;
      busy   <= busy_next;
      done   <= done_next;
    end
  end

  // Read data register, held until the next read captures.
  always_ff @(posedge clk) begin
    if (reset)        rd_data <= 8'h00;
    else if (capture) rd_data <= ad_sample;
  end

endmodule
